traffic_interval_timer: RTL and testbench
=========================================

TRAFFIC_INTERVAL_TIMER -- requirements
Module: traffic_interval_timer

Interface
REQ-001 Parameter CLK_FREQ, default 10, clock cycles per second; legal range is 1 or greater.
REQ-002 Parameter SEC_W, default 8, width of the duration and remaining-seconds fields; legal range is 1 or greater.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 start  input  1  level-sampled request to begin a timed interval.
REQ-006 duration  input  SEC_W  interval length in whole seconds, sampled only on an accepted start.
REQ-007 pause  input  1  level; while high, counting is frozen.
REQ-008 abort  input  1  level; cancels the active interval.
REQ-009 busy  output  1  high while an interval is active (RUN or HOLD state).
REQ-010 done  output  1  one-cycle pulse on normal completion.
REQ-011 sec_tick  output  1  one-cycle pulse in the cycle after each seconds decrement.
REQ-012 remaining  output  SEC_W  seconds left; intended for the countdown display.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and HOLD; busy is high exactly when the state is not IDLE.
REQ-014 The prescaler SHALL be max(1,$clog2(CLK_FREQ)) bits wide and SHALL count 0 to CLK_FREQ-1.
REQ-015 In IDLE, if start=1, abort=0 and duration>0, the block SHALL latch duration into remaining, clear the prescaler and go to RUN at that edge (edge E0).
REQ-016 In IDLE, if start=1, abort=0 and duration=0, the block SHALL pulse done in the next cycle, stay in IDLE and keep remaining at 0.
REQ-017 The block SHALL ignore start while busy; duration is not re-sampled.
REQ-018 In RUN with pause=0, each edge SHALL increment the prescaler; when the prescaler equals CLK_FREQ-1, it SHALL wrap to 0, remaining SHALL decrement by 1, and sec_tick SHALL be 1 for the following cycle.
REQ-019 When the decrement takes remaining from 1 to 0, the state SHALL go to IDLE, busy SHALL drop, and done SHALL be 1 for exactly one cycle. Done is first high in the cycle after edge E0+duration*CLK_FREQ.
REQ-020 In RUN with pause=1, the state SHALL go to HOLD, and the prescaler and remaining SHALL not change on that edge.
REQ-021 In HOLD, the prescaler and remaining SHALL be frozen; when pause=0, the state SHALL return to RUN and counting SHALL resume on the next edge.
REQ-022 Each pause-high cycle SHALL delay done by exactly one cycle.
REQ-023 While busy, abort=1 SHALL force IDLE at the next edge, clear remaining and the prescaler, and suppress done and sec_tick.
REQ-024 Abort SHALL have priority over pause, completion and start. If abort and the final decrement coincide, no done pulse is produced.
REQ-025 Start is accepted in the cycle done is high, since the state is then IDLE; this gives back-to-back intervals with no gap.
REQ-026 With CLK_FREQ=1, remaining SHALL decrement on every RUN edge.
REQ-027 remaining SHALL never underflow below 0, and the prescaler SHALL never exceed CLK_FREQ-1.
REQ-028 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-029 While rst_n=0, the block SHALL immediately force state=IDLE, prescaler=0, remaining=0, busy=0, done=0 and sec_tick=0, whatever the clock is doing.
REQ-030 A reset during RUN or HOLD SHALL discard the interval with no done pulse.
REQ-031 After rst_n rises, the first start SHALL be acceptable on the first rising clock edge.

Verification (CLK_FREQ=10, SEC_W=8)
REQ-032 Scenario: start with duration=25 -> busy=1 and remaining=25 after E0; 25 sec_tick pulses; done pulses one cycle after E0+250; then busy=0 and remaining=0.
REQ-033 Scenario: duration=4, pause high for 7 cycles starting 12 cycles after E0 -> remaining holds at 3 during the pause; done comes one cycle after E0+47.
REQ-034 Scenario: duration=4, abort pulsed one cycle, 15 cycles after E0 -> busy=0 and remaining=0 next cycle; no done; further sec_tick stays 0.
REQ-035 Scenario: duration=0 with start -> done=1 in the next cycle only; busy stays 0.
REQ-036 Scenario: duration=4 running, start re-asserted with duration=9 -> ignored, done still at E0+40; start held with duration=9 in the done cycle -> new interval, remaining=9, done 90 cycles later.
REQ-037 Scenario: rst_n driven low midway between clock edges at remaining=2 -> all outputs go to 0 without waiting for a clock edge; no done after rst_n rises.

Source files
------------

// File: rtl/traffic_interval_timer.sv
// Countdown interval timer for traffic-light phases: counts whole seconds using a
// CLK_FREQ-cycle prescaler, with pause (freeze) and abort (cancel) controls.
module traffic_interval_timer #(
    parameter int CLK_FREQ = 10,
    parameter int SEC_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SEC_W-1:0] duration,
    input  logic             pause,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             sec_tick,
    output logic [SEC_W-1:0] remaining
);

    localparam int PS_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_FREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    state_t          state;
    logic [PS_W-1:0] prescaler;

    // Leaving HOLD counts on the same edge, so each pause-high edge costs exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            prescaler <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sec_tick  <= 1'b0;
        end else begin
            done     <= 1'b0;
            sec_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        if (duration != '0) begin
                            remaining <= duration;
                            prescaler <= '0;
                            state     <= RUN;
                            busy      <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
                        prescaler <= '0;
                    end else if (pause) begin
                        state <= HOLD;
                    end else begin
                        state <= RUN;
                        if (prescaler == PS_MAX) begin
                            prescaler <= '0;
                            remaining <= remaining - SEC_W'(1);
                            sec_tick  <= 1'b1;
                            if (remaining == SEC_W'(1)) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            prescaler <= prescaler + PS_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_interval_timer.sv
// Self-checking bench for traffic_interval_timer: vector table, directed multi-cycle
// scenarios and randomized traffic against an elapsed-cycle reference model.
module tb_traffic_interval_timer;

    localparam int CLK_FREQ = 10;
    localparam int SEC_W    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [SEC_W-1:0] duration;
    logic             pause;
    logic             abort;
    logic             busy;
    logic             done;
    logic             sec_tick;
    logic [SEC_W-1:0] remaining;

    int checks = 0;
    int errors = 0;

    traffic_interval_timer #(
        .CLK_FREQ(CLK_FREQ),
        .SEC_W   (SEC_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .duration (duration),
        .pause    (pause),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .sec_tick (sec_tick),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    // Reference model: an interval is duration*CLK_FREQ counted (non-paused) edges long.
    bit m_active  = 1'b0;
    bit m_done    = 1'b0;
    bit m_tick    = 1'b0;
    int m_dur     = 0;
    int m_counted = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active  = 1'b0;
            m_done    = 1'b0;
            m_tick    = 1'b0;
            m_dur     = 0;
            m_counted = 0;
        end else begin
            m_done = 1'b0;
            m_tick = 1'b0;
            if (!m_active) begin
                if (start && !abort) begin
                    if (duration > 0) begin
                        m_active  = 1'b1;
                        m_dur     = int'(duration);
                        m_counted = 0;
                    end else begin
                        m_done = 1'b1;
                    end
                end
            end else if (abort) begin
                m_active  = 1'b0;
                m_dur     = 0;
                m_counted = 0;
            end else if (!pause) begin
                m_counted++;
                if (m_counted % CLK_FREQ == 0) m_tick = 1'b1;
                if (m_counted == m_dur * CLK_FREQ) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end
    end

    function automatic int modelRemaining();
        return m_active ? (m_dur - m_counted / CLK_FREQ) : 0;
    endfunction

    typedef struct {
        logic             start;
        logic [SEC_W-1:0] duration;
        logic             pause;
        logic             abort;
        logic             busy;
        logic             done;
        logic             sec_tick;
        logic [SEC_W-1:0] remaining;
    } vec_t;

    vec_t vecs[19];

    task automatic checkInt(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input logic eb, input logic ed,
                               input logic et, input int er);
        checkInt({name, ".busy"}, int'(busy), int'(eb));
        checkInt({name, ".done"}, int'(done), int'(ed));
        checkInt({name, ".sec_tick"}, int'(sec_tick), int'(et));
        checkInt({name, ".remaining"}, int'(remaining), er);
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, m_active, m_done, m_tick, modelRemaining());
    endtask

    // Drives inputs from the current (negedge) time, then returns at the next negedge.
    task automatic applyStimulus(input logic s, input logic [SEC_W-1:0] d,
                                 input logic p, input logic a);
        start    = s;
        duration = d;
        pause    = p;
        abort    = a;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int ticks;
        int done_cnt;
        int done_at;
        int done_at2;

        rst_n    = 1'b0;
        start    = 1'b0;
        duration = '0;
        pause    = 1'b0;
        abort    = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset", 1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;

        vecs[0]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b1, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[5]  = '{1'b1, 8'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        for (int i = 6; i <= 12; i++)
            vecs[i] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[13] = '{1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[14] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[15] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0};
        vecs[16] = '{1'b1, 8'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        vecs[17] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[18] = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].start, vecs[i].duration, vecs[i].pause, vecs[i].abort);
            checkOutput($sformatf("vec%0d", i), vecs[i].busy, vecs[i].done,
                        vecs[i].sec_tick, int'(vecs[i].remaining));
        end

        // 25-second interval: 25 ticks, done one cycle after E0+250.
        applyStimulus(1'b1, 8'd25, 1'b0, 1'b0);
        checkOutput("s25_e0", 1'b1, 1'b0, 1'b0, 25);
        ticks = 0; done_cnt = 0; done_at = -1;
        for (int k = 1; k <= 260; k++) begin
            applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
            if (sec_tick) ticks++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            checkModel("s25_run");
        end
        checkInt("s25_ticks", ticks, 25);
        checkInt("s25_done_at", done_at, 250);
        checkInt("s25_done_count", done_cnt, 1);
        checkOutput("s25_end", 1'b0, 1'b0, 1'b0, 0);

        // Pause for 7 cycles from E0+12 delays done by 7 cycles.
        applyStimulus(1'b1, 8'd4, 1'b0, 1'b0);
        done_at = -1;
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(1'b0, 8'd0, (k >= 12 && k <= 18), 1'b0);
            if (k >= 12 && k <= 18) checkInt("pause_hold_rem", int'(remaining), 3);
            if (done && done_at < 0) done_at = k;
            checkModel("pause_run");
        end
        checkInt("pause_done_at", done_at, 47);

        // Abort 15 cycles into a 4-second interval.
        applyStimulus(1'b1, 8'd4, 1'b0, 1'b0);
        ticks = 0; done_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(1'b0, 8'd0, 1'b0, (k == 15));
            if (k == 15) checkOutput("abort_next", 1'b0, 1'b0, 1'b0, 0);
            if (k >= 15 && sec_tick) ticks++;
            if (done) done_cnt++;
        end
        checkInt("abort_done_count", done_cnt, 0);
        checkInt("abort_ticks_after", ticks, 0);

        // Start ignored while busy, then accepted in the done cycle.
        applyStimulus(1'b1, 8'd4, 1'b0, 1'b0);
        done_at = -1; done_at2 = -1;
        for (int k = 1; k <= 140; k++) begin
            applyStimulus((k == 5 || k == 41), 8'd9, 1'b0, 1'b0);
            if (k == 41) checkOutput("b2b_restart", 1'b1, 1'b0, 1'b0, 9);
            if (done) begin
                if (done_at < 0) done_at = k;
                else if (done_at2 < 0) done_at2 = k;
            end
            checkModel("b2b_run");
        end
        checkInt("b2b_first_done", done_at, 40);
        checkInt("b2b_second_done", done_at2, 131);

        // Asynchronous reset between clock edges at remaining=2.
        applyStimulus(1'b1, 8'd4, 1'b0, 1'b0);
        for (int k = 1; k <= 25; k++) applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
        checkInt("areset_pre_rem", int'(remaining), 2);
        #2 rst_n = 1'b0;
        #1 checkOutput("areset_async", 1'b0, 1'b0, 1'b0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
            if (done || busy) done_cnt++;
        end
        checkInt("areset_no_done", done_cnt, 0);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(($urandom_range(0, 3) == 0), SEC_W'($urandom_range(0, 4)),
                          ($urandom_range(0, 7) == 0), ($urandom_range(0, 40) == 0));
            checkModel("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
